// File: rtl/inst_fetch_queue.sv
// Fetch front end: owns the fetch PC, keeps one memory read outstanding and queues results for IF/ID.
// Optional macro FETCH_BYPASS_EN adds a same-cycle response-to-output path when the queue is empty.
//
// state  | meaning
// S_IDLE | first cycle after reset, no request yet
// S_REQ  | presenting fetch_pc to memory (when a slot is free)
// S_WAIT | one request outstanding, response will be queued
// S_DROP | one request outstanding, response is stale after a redirect
module inst_fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int PC_WIDTH   = 5,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [PC_WIDTH-1:0]   mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [INST_WIDTH-1:0] mem_resp_inst,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [PC_WIDTH-1:0]   out_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t                r_state;
  logic [PC_WIDTH-1:0]   r_fetch_pc;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [PC_WIDTH-1:0]   r_pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];

  logic                  w_empty;
  logic                  w_full;
  logic                  w_req_fire;
  logic                  w_resp_live;
  logic                  w_bypass;
  logic                  w_byp_take;
  logic                  w_push;
  logic                  w_pop;
  logic [PC_WIDTH-1:0]   w_resp_pc;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_req_fire  = mem_req_valid && mem_req_ready;
  // fetch_pc has already advanced past the outstanding request
  assign w_resp_pc   = r_fetch_pc - PC_WIDTH'(1);
  assign w_resp_live = (r_state == S_WAIT) && mem_resp_valid && !redirect;

  assign mem_req_valid = (r_state == S_REQ) && !w_full;
  assign mem_req_addr  = r_fetch_pc;

`ifdef FETCH_BYPASS_EN
  assign w_bypass   = w_resp_live && w_empty;
  assign w_byp_take = w_bypass && out_ready;
  assign out_valid  = (!w_empty || w_bypass) && !redirect;
  assign out_inst   = w_bypass ? mem_resp_inst : r_inst_mem[r_rd_ptr];
  assign out_pc     = w_bypass ? w_resp_pc     : r_pc_mem[r_rd_ptr];
`else
  assign w_bypass   = 1'b0;
  assign w_byp_take = 1'b0;
  assign out_valid  = !w_empty && !redirect;
  assign out_inst   = r_inst_mem[r_rd_ptr];
  assign out_pc     = r_pc_mem[r_rd_ptr];
`endif

  assign w_pop  = out_valid && out_ready && !w_bypass;
  assign w_push = w_resp_live && !w_byp_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (redirect) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= redirect_pc;
      unique case (r_state)
        S_IDLE:  r_state <= S_REQ;
        S_REQ:   r_state <= w_req_fire ? S_DROP : S_REQ;
        S_WAIT:  r_state <= mem_resp_valid ? S_REQ : S_DROP;
        S_DROP:  r_state <= mem_resp_valid ? S_REQ : S_DROP;
        default: r_state <= S_IDLE;
      endcase
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]   <= w_resp_pc;
        r_inst_mem[r_wr_ptr] <= mem_resp_inst;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
      unique case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (w_req_fire) begin
            r_state    <= S_WAIT;
            r_fetch_pc <= r_fetch_pc + PC_WIDTH'(1);
          end
        end
        S_WAIT:  if (mem_resp_valid) r_state <= S_REQ;
        S_DROP:  if (mem_resp_valid) r_state <= S_REQ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised bench for inst_fetch_queue: memory stub plus a queue-level reference model.
// Handles both default and FETCH_BYPASS_EN builds.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PCW   = 5;
  localparam int IW    = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mem_req_valid;
  logic           mem_req_ready = 1'b0;
  logic [PCW-1:0] mem_req_addr;
  logic           mem_resp_valid = 1'b0;
  logic [IW-1:0]  mem_resp_inst = '0;
  logic           redirect = 1'b0;
  logic [PCW-1:0] redirect_pc = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [IW-1:0]  out_inst;
  logic [PCW-1:0] out_pc;

  inst_fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW), .INST_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_inst(mem_resp_inst),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  inst;
  } ent_t;

  ent_t           q[$];
  logic [IW-1:0]  mem_img [32];
  logic [PCW-1:0] m_fetch = '0;
  logic [PCW-1:0] m_req_pc = '0;
  bit             m_started = 0, m_pending = 0, m_stale = 0;
  int             timer = 0;

  int n_vec = 0, n_err = 0;
  int p_mready = 100, p_oready = 100, p_redir = 0, p_spur = 0, lat_min = 0, max_lat = 0;
  bit f_redir = 0;
  logic [PCW-1:0] f_rpc = '0;
  int acc_log[$], pop_log[$];
  logic [IW-1:0] popi_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model for the current cycle, then advance the model across the next edge.
  task automatic eval();
    bit exp_rv, exp_ov, byp, acc, rsp, pop;
    logic [PCW-1:0] e_pc;
    logic [IW-1:0]  e_inst;
    exp_rv = m_started && !m_pending && (q.size() < DEPTH);
    byp = 0;
`ifdef FETCH_BYPASS_EN
    byp = (q.size() == 0) && m_pending && !m_stale && mem_resp_valid && !redirect;
`endif
    exp_ov = ((q.size() != 0) || byp) && !redirect;
    if (q.size() != 0) begin
      e_pc = q[0].pc; e_inst = q[0].inst;
    end else begin
      e_pc = m_req_pc; e_inst = mem_img[m_req_pc];
    end
    chk("req_valid", 64'(mem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", 64'(mem_req_addr), 64'(m_fetch));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      chk("out_pc", 64'(out_pc), 64'(e_pc));
      chk("out_inst", 64'(out_inst), 64'(e_inst));
    end
    if (mem_req_valid && mem_req_ready) acc_log.push_back(int'(mem_req_addr));
    if (out_valid && out_ready) begin
      pop_log.push_back(int'(out_pc));
      popi_log.push_back(out_inst);
    end

    acc = exp_rv && mem_req_ready;
    rsp = mem_resp_valid && m_pending;
    pop = exp_ov && out_ready;
    if (redirect) begin
      q.delete();
      if (acc) begin
        m_pending = 1; m_stale = 1; m_req_pc = m_fetch;
        timer = $urandom_range(max_lat, lat_min);
      end else if (rsp) begin
        m_pending = 0; m_stale = 0;
      end else if (m_pending) begin
        m_stale = 1;
      end
      m_fetch = redirect_pc;
    end else begin
      if (pop && !byp) void'(q.pop_front());
      if (rsp) begin
        if (!m_stale && !(byp && pop)) q.push_back('{pc: m_req_pc, inst: mem_img[m_req_pc]});
        m_pending = 0; m_stale = 0;
      end
      if (acc) begin
        m_pending = 1; m_stale = 0; m_req_pc = m_fetch;
        m_fetch = m_fetch + PCW'(1);
        timer = $urandom_range(max_lat, lat_min);
      end
    end
    m_started = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mem_req_ready = ($urandom_range(99) < p_mready);
    out_ready     = ($urandom_range(99) < p_oready);
    if (f_redir) begin
      redirect = 1'b1; redirect_pc = f_rpc; f_redir = 0;
    end else begin
      redirect    = ($urandom_range(999) < p_redir);
      redirect_pc = PCW'($urandom);
    end
    if (m_pending && timer == 0) begin
      mem_resp_valid = 1'b1;
      mem_resp_inst  = mem_img[m_req_pc];
    end else begin
      if (m_pending) timer--;
      mem_resp_valid = !m_pending && ($urandom_range(99) < p_spur);
      mem_resp_inst  = $urandom;
    end
    @(negedge clk);
    eval();
  endtask

  task automatic clear_logs();
    acc_log.delete(); pop_log.delete(); popi_log.delete();
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 32; i++) mem_img[i] = $urandom;
    mem_img[3] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    chk("rst_req_valid", 64'(mem_req_valid), 64'(0));
    chk("rst_req_addr", 64'(mem_req_addr), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_inst", 64'(out_inst), 64'(0));
    chk("rst_out_pc", 64'(out_pc), 64'(0));
    rst_n = 1'b1;
    eval();

    // Streaming: always ready, single-cycle memory
    repeat (80) step();
    chk("seqA_acc_len", 64'(acc_log.size() >= 33), 64'(1));
    for (int i = 0; i < 33 && i < acc_log.size(); i++) chk("seqA_addr", 64'(acc_log[i]), 64'(i % 32));
    chk("seqA_pop_len", 64'(pop_log.size() >= 33), 64'(1));
    for (int i = 0; i < 33 && i < pop_log.size(); i++) begin
      chk("seqA_out_pc", 64'(pop_log[i]), 64'(i % 32));
      chk("seqA_out_inst", 64'(popi_log[i]), 64'(mem_img[i % 32]));
    end

    // Back-pressure: fill to DEPTH from pc 0, then drain
    f_redir = 1; f_rpc = '0; p_oready = 0;
    repeat (20) step();
    chk("full_req_valid", 64'(mem_req_valid), 64'(0));
    chk("full_out_valid", 64'(out_valid), 64'(1));
    chk("full_head_pc", 64'(out_pc), 64'(0));
    clear_logs();
    p_oready = 100;
    repeat (8) step();
    chk("drain_len", 64'(pop_log.size() >= 4), 64'(1));
    for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("drain_pc", 64'(pop_log[i]), 64'(i));

    // Memory stalls with address 7 pending
    f_redir = 1; f_rpc = 5'd7; p_mready = 0;
    repeat (6) step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 64'(mem_req_valid), 64'(1));
      chk("stall_addr", 64'(mem_req_addr), 64'(7));
    end
    clear_logs();
    p_mready = 100;
    repeat (6) step();
    chk("stall_pop_len", 64'(pop_log.size() >= 1), 64'(1));
    if (pop_log.size() >= 1) chk("stall_out_pc", 64'(pop_log[0]), 64'(7));

    // Redirect to 0x10 while a slow response is outstanding
    lat_min = 2; max_lat = 2;
    budget = 30;
    while (!(m_pending && !m_stale) && budget > 0) begin step(); budget--; end
    chk("wait_reached", 64'(budget > 0), 64'(1));
    f_redir = 1; f_rpc = 5'h10;
    clear_logs();
    repeat (14) step();
    chk("redir_acc_len", 64'(acc_log.size() >= 1), 64'(1));
    if (acc_log.size() >= 1) chk("redir_first_addr", 64'(acc_log[0]), 64'(16));
    chk("redir_pop_len", 64'(pop_log.size() >= 1), 64'(1));
    if (pop_log.size() >= 1) chk("redir_first_pc", 64'(pop_log[0]), 64'(16));

    // Redirect coinciding with a pop at count 3
    lat_min = 0; max_lat = 0; p_oready = 0;
    f_redir = 1; f_rpc = 5'd20;
    budget = 40;
    step();
    while (q.size() != 3 && budget > 0) begin step(); budget--; end
    chk("cnt3_reached", 64'(budget > 0), 64'(1));
    p_oready = 100; f_redir = 1; f_rpc = 5'd9;
    step();
    chk("redir_pop_out_valid", 64'(out_valid), 64'(0));
    step();
    chk("post_redir_out_valid", 64'(out_valid), 64'(0));

    // Random traffic
    p_mready = 70; p_oready = 60; p_redir = 30; p_spur = 10; lat_min = 0; max_lat = 3;
    repeat (2500) step();
    p_oready = 95; p_mready = 40; p_redir = 10;
    repeat (1000) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
